// File: rtl/vga_timing_generator.sv
// Raster timing generator: a single (h, v) position counter pair from which
// registered sync, display-enable, pixel coordinates and line/frame strobes are decoded.
module vga_timing_generator #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FRONT    = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BACK     = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FRONT    = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BACK     = 33,
   parameter logic        H_SYNC_POL = 1'b0,
   parameter logic        V_SYNC_POL = 1'b0,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk25MHz,
   input  logic             rst_n,
   input  logic             enable,
   output logic [CNT_W-1:0] hCount,
   output logic [CNT_W-1:0] vCount,
   output logic             hSync,
   output logic             vSync,
   output logic             displayEnable,
   output logic [CNT_W-1:0] pixelX,
   output logic [CNT_W-1:0] pixelY,
   output logic             lineStart,
   output logic             frameStart
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
       V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
       CNT_W < 1 || CNT_W > 31) begin : g_bad_param
      $error("vga_timing_generator: every timing parameter must be >= 1 and CNT_W in 1..31");
   end
   if (longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
       longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_total
      $error("vga_timing_generator: H_TOTAL/V_TOTAL exceed the CNT_W counter range");
   end

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FRONT);
   localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FRONT);
   localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] v_q, v_d;
   logic [CNT_W-1:0] hcount_q, hcount_d;
   logic [CNT_W-1:0] vcount_q, vcount_d;
   logic [CNT_W-1:0] pixx_q, pixx_d;
   logic [CNT_W-1:0] pixy_q, pixy_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             de_q, de_d;
   logic             line_q, line_d;
   logic             frame_q, frame_d;

   logic             h_wrap;
   logic             in_active;
   logic             in_hsync;
   logic             in_vsync;

   // h_q/v_q hold the position to be presented on the next enabled edge,
   // so every output register is loaded from the same decode of that position.
   always_comb begin
      h_wrap    = (h_q == H_LAST);
      in_active = (h_q < H_ACT_END) && (v_q < V_ACT_END);
      in_hsync  = (h_q >= HS_START) && (h_q < HS_END);
      in_vsync  = (v_q >= VS_START) && (v_q < VS_END);
   end

   always_comb begin
      h_d      = h_q;
      v_d      = v_q;
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      pixx_d   = pixx_q;
      pixy_d   = pixy_q;
      hsync_d  = hsync_q;
      vsync_d  = vsync_q;
      de_d     = de_q;
      line_d   = 1'b0;
      frame_d  = 1'b0;

      if (enable) begin
         hcount_d = h_q;
         vcount_d = v_q;
         de_d     = in_active;
         pixx_d   = in_active ? h_q : '0;
         pixy_d   = in_active ? v_q : '0;
         hsync_d  = in_hsync ? H_SYNC_POL : ~H_SYNC_POL;
         vsync_d  = in_vsync ? V_SYNC_POL : ~V_SYNC_POL;
         line_d   = (h_q == '0);
         frame_d  = (h_q == '0) && (v_q == '0);

         if (h_wrap) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk25MHz) begin
      if (!rst_n) begin
         h_q      <= '0;
         v_q      <= '0;
         hcount_q <= '0;
         vcount_q <= '0;
         pixx_q   <= '0;
         pixy_q   <= '0;
         hsync_q  <= ~H_SYNC_POL;
         vsync_q  <= ~V_SYNC_POL;
         de_q     <= 1'b0;
         line_q   <= 1'b0;
         frame_q  <= 1'b0;
      end else begin
         h_q      <= h_d;
         v_q      <= v_d;
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         pixx_q   <= pixx_d;
         pixy_q   <= pixy_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         de_q     <= de_d;
         line_q   <= line_d;
         frame_q  <= frame_d;
      end
   end

   assign hCount        = hcount_q;
   assign vCount        = vcount_q;
   assign pixelX        = pixx_q;
   assign pixelY        = pixy_q;
   assign hSync         = hsync_q;
   assign vSync         = vsync_q;
   assign displayEnable = de_q;
   assign lineStart     = line_q;
   assign frameStart    = frame_q;

endmodule
